tone_scheduler: RTL and testbench

Shares the single tone generator (note index → divider → square wave) between the background-music note stream and three game sound effects: piece drop, line clear and game over. It arbitrates by priority, plays each effect from an internal note table, and freezes the background-music step counter while an effect owns the buzzer. It sits between the music note ROM output and the divider-calculation stage.

---
 rtl/tone_if.sv | 32 +++
 rtl/tone_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_tone_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/tone_if.sv
// Tone-scheduler bus: music note in, effect requests, scheduled note/status out.
// With TONE_MUTE_EN defined the bus also carries a mute input.
interface tone_if;
    logic [4:0] bgm_note;
    logic       req_drop;
    logic       req_clear;
    logic       req_over;
    logic       restart;
`ifdef TONE_MUTE_EN
    logic       mute;
`endif
    logic [4:0] note;
    logic       bgm_hold;
    logic       busy;
    logic [1:0] sfx_id;

    modport master (
`ifdef TONE_MUTE_EN
        output mute,
`endif
        output bgm_note, req_drop, req_clear, req_over, restart,
        input  note, bgm_hold, busy, sfx_id
    );

    modport slave (
`ifdef TONE_MUTE_EN
        input  mute,
`endif
        input  bgm_note, req_drop, req_clear, req_over, restart,
        output note, bgm_hold, busy, sfx_id
    );
endinterface

// File: rtl/tone_scheduler.sv
// Shares one tone generator between background music and three prioritised sound effects.
// Optional macro TONE_MUTE_EN adds a mute input that forces the note output to 0.
module tone_scheduler #(
    parameter int STEP_CYCLES = 3_125_000,
    parameter int GAP_STEPS   = 1
) (
    input  logic    clk,
    input  logic    rst,
    tone_if.slave   bus
);

    localparam int TW = $clog2(STEP_CYCLES);
    localparam int GW = (GAP_STEPS > 1) ? $clog2(GAP_STEPS) : 1;

    typedef enum logic [1:0] {IDLE, PLAY, GAP, HALT} state_t;

    state_t          state_reg, state_next;
    logic [1:0]      sfx_reg, sfx_next;
    logic [2:0]      idx_reg, idx_next;
    logic [1:0]      pending_reg, pending_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [GW-1:0]   gap_reg, gap_next;
    logic [4:0]      note_reg, note_next;

    logic [3:1]      req_vec;
    logic            step_tick;
    logic [1:0]      cur_pri;
    logic [1:0]      top_pri;
    logic [1:0]      second_pri;
    logic [1:0]      lower_pri;

    // Highest requested priority strictly below limit (0 when none).
    function automatic logic [1:0] highest_below(input logic [3:1] req, input logic [2:0] limit);
        logic [1:0] r;
        r = 2'd0;
        if (req[3] && limit > 3'd3)
            r = 2'd3;
        else if (req[2] && limit > 3'd2)
            r = 2'd2;
        else if (req[1] && limit > 3'd1)
            r = 2'd1;
        return r;
    endfunction

    function automatic logic [2:0] last_idx(input logic [1:0] sfx);
        logic [2:0] r;
        case (sfx)
            2'd1:    r = 3'd1;
            2'd2:    r = 3'd3;
            2'd3:    r = 3'd5;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] table_note(input logic [1:0] sfx, input logic [2:0] idx);
        logic [4:0] r;
        r = 5'd0;
        case ({sfx, idx})
            {2'd1, 3'd0}: r = 5'd8;
            {2'd1, 3'd1}: r = 5'd1;
            {2'd2, 3'd0}: r = 5'd13;
            {2'd2, 3'd1}: r = 5'd15;
            {2'd2, 3'd2}: r = 5'd17;
            {2'd2, 3'd3}: r = 5'd20;
            {2'd3, 3'd0}: r = 5'd17;
            {2'd3, 3'd1}: r = 5'd15;
            {2'd3, 3'd2}: r = 5'd13;
            {2'd3, 3'd3}: r = 5'd12;
            {2'd3, 3'd4}: r = 5'd10;
            {2'd3, 3'd5}: r = 5'd8;
            default:      r = 5'd0;
        endcase
        return r;
    endfunction

    assign req_vec    = {bus.req_over, bus.req_clear, bus.req_drop};
    assign step_tick  = (timer_reg == TW'(STEP_CYCLES - 1));
    // Owner as seen on sfx_id: the gap between effects belongs to nobody.
    assign cur_pri    = (state_reg == PLAY) ? sfx_reg :
                        (state_reg == HALT) ? 2'd3 : 2'd0;
    assign top_pri    = highest_below(req_vec, 3'd4);
    assign second_pri = highest_below(req_vec, {1'b0, top_pri});
    assign lower_pri  = highest_below(req_vec, {1'b0, cur_pri});

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            sfx_reg     <= 2'd0;
            idx_reg     <= 3'd0;
            pending_reg <= 2'd0;
            timer_reg   <= '0;
            gap_reg     <= '0;
            note_reg    <= 5'd0;
        end else begin
            state_reg   <= state_next;
            sfx_reg     <= sfx_next;
            idx_reg     <= idx_next;
            pending_reg <= pending_next;
            timer_reg   <= timer_next;
            gap_reg     <= gap_next;
            note_reg    <= note_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        sfx_next     = sfx_reg;
        idx_next     = idx_reg;
        pending_next = pending_reg;
        gap_next     = gap_reg;
        if (state_reg == PLAY || state_reg == GAP)
            timer_next = step_tick ? '0 : timer_reg + TW'(1);
        else
            timer_next = '0;

        if (bus.restart) begin
            state_next   = IDLE;
            sfx_next     = 2'd0;
            idx_next     = 3'd0;
            pending_next = 2'd0;
            gap_next     = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (top_pri != 2'd0) begin
                        state_next   = PLAY;
                        sfx_next     = top_pri;
                        idx_next     = 3'd0;
                        timer_next   = '0;
                        pending_next = second_pri;
                    end
                end
                PLAY, GAP: begin
                    if (top_pri > cur_pri) begin
                        // Preemption discards the running effect; pending is kept.
                        state_next = PLAY;
                        sfx_next   = top_pri;
                        idx_next   = 3'd0;
                        timer_next = '0;
                    end else begin
                        if (lower_pri > pending_reg)
                            pending_next = lower_pri;
                        if (state_reg == PLAY && step_tick) begin
                            if (idx_reg == last_idx(sfx_reg)) begin
                                state_next = (sfx_reg == 2'd3) ? HALT : GAP;
                                gap_next   = '0;
                            end else begin
                                idx_next = idx_reg + 3'd1;
                            end
                        end else if (state_reg == GAP && step_tick) begin
                            if (gap_reg == GW'(GAP_STEPS - 1)) begin
                                if (pending_reg != 2'd0) begin
                                    state_next   = PLAY;
                                    sfx_next     = pending_reg;
                                    idx_next     = 3'd0;
                                    timer_next   = '0;
                                    pending_next = 2'd0;
                                end else begin
                                    state_next = IDLE;
                                    sfx_next   = 2'd0;
                                end
                            end else begin
                                gap_next = gap_reg + GW'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic: note is computed from the upcoming state so it lands with the transition.
    always_comb begin
        case (state_next)
            IDLE:    note_next = bus.bgm_note;
            PLAY:    note_next = table_note(sfx_next, idx_next);
            default: note_next = 5'd0;
        endcase
`ifdef TONE_MUTE_EN
        if (bus.mute)
            note_next = 5'd0;
`endif
    end

    assign bus.note     = note_reg;
    assign bus.busy     = (state_reg != IDLE);
    assign bus.bgm_hold = (state_reg != IDLE);
    assign bus.sfx_id   = cur_pri;

endmodule

// File: tb/tb_tone_scheduler.sv
// Directed bench for tone_scheduler with STEP_CYCLES=4, GAP_STEPS=1.
module tb_tone_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    tone_if bus ();

    tone_scheduler #(.STEP_CYCLES(4), .GAP_STEPS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    // Check note/sfx_id/bgm_hold/busy for a number of consecutive cycles.
    task automatic expect_run(input string tag, input logic [4:0] n_e, input logic [1:0] s_e,
                              input logic h_e, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            chk({tag, "_note"}, {3'd0, bus.note}, {3'd0, n_e});
            chk({tag, "_sfx"},  {6'd0, bus.sfx_id}, {6'd0, s_e});
            chk({tag, "_hold"}, {7'd0, bus.bgm_hold}, {7'd0, h_e});
            chk({tag, "_busy"}, {7'd0, bus.busy}, {7'd0, h_e});
            tick();
        end
        $display("run %s note=%0d sfx=%0d hold=%0d cycles=%0d", tag, n_e, s_e, h_e, cycles);
    endtask

    initial begin
        bus.bgm_note  = 5'd0;
        bus.req_drop  = 1'b0;
        bus.req_clear = 1'b0;
        bus.req_over  = 1'b0;
        bus.restart   = 1'b0;
`ifdef TONE_MUTE_EN
        bus.mute      = 1'b0;
`endif
        #2 rst = 1'b0;
        tick();
        tick();
        expect_run("reset", 5'd0, 2'd0, 1'b0, 1);
        rst = 1'b1;
        tick();

        // 1. IDLE pass-through with one cycle of latency
        bus.bgm_note = 5'd17;
        chk("pass_latency", {3'd0, bus.note}, 8'd0);
        tick();
        expect_run("pass", 5'd17, 2'd0, 1'b0, 2);

        // 2. clear effect followed by gap and hand-back
        bus.bgm_note  = 5'd5;
        bus.req_clear = 1'b1;
        tick();
        bus.req_clear = 1'b0;
        expect_run("clr0", 5'd13, 2'd2, 1'b1, 4);
        expect_run("clr1", 5'd15, 2'd2, 1'b1, 4);
        expect_run("clr2", 5'd17, 2'd2, 1'b1, 4);
        expect_run("clr3", 5'd20, 2'd2, 1'b1, 4);
        expect_run("clrgap", 5'd0, 2'd0, 1'b1, 4);
        expect_run("clridle", 5'd5, 2'd0, 1'b0, 2);

        // 3. drop during clear step 1 is queued and plays after the gap
        bus.req_clear = 1'b1;
        tick();
        bus.req_clear = 1'b0;
        expect_run("q_clr0", 5'd13, 2'd2, 1'b1, 4);
        bus.req_drop = 1'b1;
        expect_run("q_clr1a", 5'd15, 2'd2, 1'b1, 1);
        bus.req_drop = 1'b0;
        expect_run("q_clr1b", 5'd15, 2'd2, 1'b1, 3);
        expect_run("q_clr2", 5'd17, 2'd2, 1'b1, 4);
        expect_run("q_clr3", 5'd20, 2'd2, 1'b1, 4);
        expect_run("q_gap1", 5'd0, 2'd0, 1'b1, 4);
        expect_run("q_drop0", 5'd8, 2'd1, 1'b1, 4);
        expect_run("q_drop1", 5'd1, 2'd1, 1'b1, 4);
        expect_run("q_gap2", 5'd0, 2'd0, 1'b1, 4);
        expect_run("q_idle", 5'd5, 2'd0, 1'b0, 2);

        // 4. over preempts drop, ends in HALT, ignores requests until restart
        bus.req_drop = 1'b1;
        tick();
        bus.req_drop = 1'b0;
        expect_run("p_drop", 5'd8, 2'd1, 1'b1, 2);
        bus.req_over = 1'b1;
        expect_run("p_drop_req", 5'd8, 2'd1, 1'b1, 1);
        bus.req_over = 1'b0;
        expect_run("p_over0", 5'd17, 2'd3, 1'b1, 4);
        expect_run("p_over1", 5'd15, 2'd3, 1'b1, 4);
        expect_run("p_over2", 5'd13, 2'd3, 1'b1, 4);
        expect_run("p_over3", 5'd12, 2'd3, 1'b1, 4);
        expect_run("p_over4", 5'd10, 2'd3, 1'b1, 4);
        expect_run("p_over5", 5'd8, 2'd3, 1'b1, 4);
        expect_run("p_halt", 5'd0, 2'd3, 1'b1, 3);
        bus.req_clear = 1'b1;
        expect_run("p_halt_req", 5'd0, 2'd3, 1'b1, 1);
        bus.req_clear = 1'b0;
        expect_run("p_halt_ign", 5'd0, 2'd3, 1'b1, 6);
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        expect_run("p_restart", 5'd5, 2'd0, 1'b0, 2);

        // 5. simultaneous requests: over plays, clear pending, restart drops it
        bus.req_drop  = 1'b1;
        bus.req_clear = 1'b1;
        bus.req_over  = 1'b1;
        tick();
        bus.req_drop  = 1'b0;
        bus.req_clear = 1'b0;
        bus.req_over  = 1'b0;
        expect_run("s_over0", 5'd17, 2'd3, 1'b1, 4);
        expect_run("s_over1", 5'd15, 2'd3, 1'b1, 4);
        expect_run("s_over2", 5'd13, 2'd3, 1'b1, 4);
        expect_run("s_over3", 5'd12, 2'd3, 1'b1, 4);
        expect_run("s_over4", 5'd10, 2'd3, 1'b1, 4);
        expect_run("s_over5", 5'd8, 2'd3, 1'b1, 4);
        expect_run("s_halt", 5'd0, 2'd3, 1'b1, 8);
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        expect_run("s_restart", 5'd5, 2'd0, 1'b0, 2);
        bus.req_drop = 1'b1;
        tick();
        bus.req_drop = 1'b0;
        expect_run("s_drop0", 5'd8, 2'd1, 1'b1, 4);
        expect_run("s_drop1", 5'd1, 2'd1, 1'b1, 4);
        expect_run("s_gap", 5'd0, 2'd0, 1'b1, 4);
        expect_run("s_idle", 5'd5, 2'd0, 1'b0, 2);

        // 6. asynchronous reset mid-effect
        bus.req_clear = 1'b1;
        tick();
        bus.req_clear = 1'b0;
        expect_run("r_clr", 5'd13, 2'd2, 1'b1, 2);
        #2 rst = 1'b0;
        #1;
        chk("r_async_note", {3'd0, bus.note}, 8'd0);
        chk("r_async_busy", {7'd0, bus.busy}, 8'd0);
        chk("r_async_sfx",  {6'd0, bus.sfx_id}, 8'd0);
        chk("r_async_hold", {7'd0, bus.bgm_hold}, 8'd0);
        $display("async reset asserted mid-effect");
        tick();
        rst = 1'b1;
        bus.bgm_note = 5'd9;
        tick();
        expect_run("r_after", 5'd9, 2'd0, 1'b0, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
